anti_theft_fsm: RTL and testbench

- Control state machine for the car-alarm system; sits directly upstream of the countdown timer.
- Watches the ignition, door and reprogram inputs, and picks which interval the timer runs.
- Issues the timer's start pulse and consumes its expired flag.
- Drives the siren and status indicator outputs.

---
 rtl/anti_theft_fsm.sv | 183 ++++++++++++++++++
 tb/tb_anti_theft_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/anti_theft_fsm.sv
// ---------------------------------------------------------------------------
// anti_theft_fsm
// Control state machine for the car-alarm system. It watches the ignition,
// door and reprogram inputs, selects the countdown interval, pulses the
// timer start and consumes the timer's expired level, and drives the siren
// and status LED.
//
// Ports
//   clock_25mhz      in   system clock
//   reset_sync       in   asynchronous active-high reset
//   ignition         in   debounced ignition switch
//   driver_door      in   1 = driver door open
//   passenger_door   in   1 = passenger door open
//   reprogram        in   one-cycle pulse, forces ARMED
//   one_hz_enable    in   one-cycle 1 Hz tick
//   expired          in   timer expired level
//   start_timer      out  one-cycle timer start pulse
//   interval         out  timer interval select
//   siren            out  siren drive
//   status_indicator out  status LED
//   fsm_state        out  current state code for the debug display
// ---------------------------------------------------------------------------
module anti_theft_fsm #(
   parameter int unsigned GUARD_CYCLES = 2,
   parameter bit          BLINK_EN     = 1'b1
) (
   input  logic       clock_25mhz,
   input  logic       reset_sync,
   input  logic       ignition,
   input  logic       driver_door,
   input  logic       passenger_door,
   input  logic       reprogram,
   input  logic       one_hz_enable,
   input  logic       expired,
   output logic       start_timer,
   output logic [1:0] interval,
   output logic       siren,
   output logic       status_indicator,
   output logic [2:0] fsm_state
);

   localparam int unsigned GUARD_W = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

   localparam logic [1:0] IV_ARM_DELAY       = 2'b00;
   localparam logic [1:0] IV_DRIVER_DELAY    = 2'b01;
   localparam logic [1:0] IV_PASSENGER_DELAY = 2'b10;
   localparam logic [1:0] IV_ALARM_ON        = 2'b11;

   typedef enum logic [2:0] {
      ST_ARMED           = 3'd0,
      ST_TRIGGERED       = 3'd1,
      ST_SOUND_ALARM     = 3'd2,
      ST_ALARM_HOLD      = 3'd3,
      ST_DISARMED        = 3'd4,
      ST_WAIT_DOOR_OPEN  = 3'd5,
      ST_WAIT_DOOR_CLOSE = 3'd6,
      ST_ARM_DELAY       = 3'd7
   } state_t;

   state_t               r_state;
   logic                 r_start;
   logic [1:0]           r_interval;
   logic                 r_siren;
   logic                 r_status;
   logic                 r_blink;
   logic [GUARD_W-1:0]   r_guard;

   state_t               w_next;
   logic                 w_pulse;
   logic [1:0]           w_interval;
   logic                 w_door_open;
   logic                 w_expired_q;
   logic                 w_enter_armed;
   logic                 w_blink_next;

   assign w_door_open = driver_door | passenger_door;

   // expired only counts once the post-start guard window has drained;
   // the timed states are the only ones that look at it
   assign w_expired_q = expired & (r_guard == '0);

   // Next-state, start pulse and interval selection
   always_comb begin
      w_next     = r_state;
      w_pulse    = 1'b0;
      w_interval = r_interval;
      if (reprogram) begin
         w_next = ST_ARMED;
      end else if (ignition && (r_state != ST_ARMED)) begin
         w_next = ST_DISARMED;
      end else begin
         case (r_state)
            ST_ARMED: begin
               if (driver_door) begin
                  w_next     = ST_TRIGGERED;
                  w_pulse    = 1'b1;
                  w_interval = IV_DRIVER_DELAY;
               end else if (passenger_door) begin
                  w_next     = ST_TRIGGERED;
                  w_pulse    = 1'b1;
                  w_interval = IV_PASSENGER_DELAY;
               end
            end
            ST_TRIGGERED: begin
               if (w_expired_q) w_next = ST_SOUND_ALARM;
            end
            ST_SOUND_ALARM: begin
               if (!w_door_open) begin
                  w_next     = ST_ALARM_HOLD;
                  w_pulse    = 1'b1;
                  w_interval = IV_ALARM_ON;
               end
            end
            ST_ALARM_HOLD: begin
               // a reopened door beats a simultaneous expiry
               if (w_door_open)      w_next = ST_SOUND_ALARM;
               else if (w_expired_q) w_next = ST_ARMED;
            end
            ST_DISARMED: begin
               // ignition is known low here, otherwise the override held us
               w_next = ST_WAIT_DOOR_OPEN;
            end
            ST_WAIT_DOOR_OPEN: begin
               if (driver_door) w_next = ST_WAIT_DOOR_CLOSE;
            end
            ST_WAIT_DOOR_CLOSE: begin
               if (!w_door_open) begin
                  w_next     = ST_ARM_DELAY;
                  w_pulse    = 1'b1;
                  w_interval = IV_ARM_DELAY;
               end
            end
            ST_ARM_DELAY: begin
               if (w_door_open)      w_next = ST_WAIT_DOOR_CLOSE;
               else if (w_expired_q) w_next = ST_ARMED;
            end
            default: w_next = ST_ARMED;
         endcase
      end
   end

   // A reprogram counts as a fresh entry into ARMED even if already there
   assign w_enter_armed = (w_next == ST_ARMED) && (reprogram || (r_state != ST_ARMED));
   assign w_blink_next  = w_enter_armed ? 1'b0 : (r_blink ^ one_hz_enable);

   // State register, guard counter and registered outputs
   always_ff @(posedge clock_25mhz or posedge reset_sync) begin
      if (reset_sync) begin
         r_state    <= ST_ARMED;
         r_start    <= 1'b0;
         r_interval <= IV_ARM_DELAY;
         r_siren    <= 1'b0;
         r_status   <= 1'b0;
         r_blink    <= 1'b0;
         r_guard    <= '0;
      end else begin
         r_state    <= w_next;
         r_start    <= w_pulse;
         r_interval <= w_interval;
         r_blink    <= w_blink_next;

         if (w_pulse)              r_guard <= GUARD_W'(GUARD_CYCLES);
         else if (r_guard != '0)   r_guard <= r_guard - GUARD_W'(1);

         r_siren <= (w_next == ST_SOUND_ALARM) || (w_next == ST_ALARM_HOLD);

         case (w_next)
            ST_ARMED:       r_status <= BLINK_EN ? w_blink_next : 1'b1;
            ST_TRIGGERED,
            ST_SOUND_ALARM,
            ST_ALARM_HOLD:  r_status <= 1'b1;
            default:        r_status <= 1'b0;
         endcase
      end
   end

   assign start_timer      = r_start;
   assign interval         = r_interval;
   assign siren            = r_siren;
   assign status_indicator = r_status;
   assign fsm_state        = r_state;

endmodule

// File: tb/tb_anti_theft_fsm.sv
// ---------------------------------------------------------------------------
// tb_anti_theft_fsm
// Self-checking bench for anti_theft_fsm: directed walk through the alarm
// scenarios with literal expectations, then randomized stimulus compared
// every cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_anti_theft_fsm;

   localparam int unsigned GUARD = 2;

   // state codes
   localparam int A  = 0;
   localparam int TR = 1;
   localparam int SA = 2;
   localparam int AH = 3;
   localparam int DI = 4;
   localparam int WO = 5;
   localparam int WC = 6;
   localparam int AD = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ig = 1'b0, dd = 1'b0, pd = 1'b0, rp = 1'b0, hz = 1'b0, ex = 1'b0;
   logic       start;
   logic [1:0] intv;
   logic       siren;
   logic       led;
   logic [2:0] st;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   anti_theft_fsm #(.GUARD_CYCLES(GUARD), .BLINK_EN(1'b1)) dut (
      .clock_25mhz     (clk),
      .reset_sync      (rst),
      .ignition        (ig),
      .driver_door     (dd),
      .passenger_door  (pd),
      .reprogram       (rp),
      .one_hz_enable   (hz),
      .expired         (ex),
      .start_timer     (start),
      .interval        (intv),
      .siren           (siren),
      .status_indicator(led),
      .fsm_state       (st)
   );

   always #20 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_st    = A;
   int m_int   = 0;
   int m_guard = 0;
   bit m_start = 1'b0;
   bit m_siren = 1'b0;
   bit m_led   = 1'b0;
   bit m_blink = 1'b0;

   function automatic bit timed(input int s);
      return (s == TR) || (s == AH) || (s == AD);
   endfunction

   function automatic bit alarming(input int s);
      return (s == SA) || (s == AH);
   endfunction

   task automatic model_reset();
      m_st = A; m_int = 0; m_guard = 0;
      m_start = 0; m_siren = 0; m_led = 0; m_blink = 0;
   endtask

   task automatic model_step(input bit i_ig, input bit i_dd, input bit i_pd,
                             input bit i_rp, input bit i_hz, input bit i_ex);
      int nxt;
      int ni;
      bit pulse;
      bit any_door;
      bit exp_ok;
      bit enter;
      any_door = i_dd || i_pd;
      exp_ok   = i_ex && (m_guard == 0) && timed(m_st);
      nxt      = m_st;
      ni       = m_int;
      pulse    = 0;
      if (i_rp)                     nxt = A;
      else if (i_ig && m_st != A)   nxt = DI;
      else begin
         case (m_st)
            A:  if (any_door) begin nxt = TR; pulse = 1; ni = i_dd ? 1 : 2; end
            TR: if (exp_ok) nxt = SA;
            SA: if (!any_door) begin nxt = AH; pulse = 1; ni = 3; end
            AH: nxt = any_door ? SA : (exp_ok ? A : AH);
            DI: nxt = WO;
            WO: if (i_dd) nxt = WC;
            WC: if (!any_door) begin nxt = AD; pulse = 1; ni = 0; end
            AD: nxt = any_door ? WC : (exp_ok ? A : AD);
            default: nxt = A;
         endcase
      end
      enter = (nxt == A) && (i_rp || m_st != A);
      if (enter)     m_blink = 0;
      else if (i_hz) m_blink = !m_blink;
      m_guard = pulse ? int'(GUARD) : ((m_guard > 0) ? m_guard - 1 : 0);
      m_st    = nxt;
      m_start = pulse;
      m_int   = ni;
      m_siren = alarming(nxt);
      m_led   = (nxt == A) ? m_blink : ((nxt == TR) || alarming(nxt));
   endtask

   // Per-cycle comparison against the model (also fires on async reset)
   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step(ig, dd, pd, rp, hz, ex);
      #1;
      if (chk_en) begin
         check("state",    int'(st),    m_st);
         check("start",    int'(start), int'(m_start));
         check("interval", int'(intv),  m_int);
         check("siren",    int'(siren), int'(m_siren));
         check("status",   int'(led),   int'(m_led));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit i_ig, input bit i_dd, input bit i_pd,
                       input bit i_rp, input bit i_hz, input bit i_ex);
      @(negedge clk);
      ig = i_ig; dd = i_dd; pd = i_pd; rp = i_rp; hz = i_hz; ex = i_ex;
      @(posedge clk);
      #2;
   endtask

   initial begin
      int toggles;
      bit prev;
      @(posedge clk);
      @(posedge clk);
      chk_en = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      // reset values
      step(0,0,0,0,0,0);
      check("lit_reset_state", int'(st), 0);
      check("lit_reset_start", int'(start), 0);
      check("lit_reset_interval", int'(intv), 0);
      check("lit_reset_status", int'(led), 0);

      // passenger door trips the alarm; expired held from +1 honoured at +3
      step(0,0,1,0,0,0);
      check("lit_trig_state", int'(st), 1);
      check("lit_trig_interval", int'(intv), 2);
      check("lit_trig_start", int'(start), 1);
      step(0,0,0,0,0,1);
      check("lit_guard1_state", int'(st), 1);
      check("lit_guard1_start", int'(start), 0);
      step(0,0,0,0,0,1);
      check("lit_guard2_state", int'(st), 1);
      step(0,0,0,0,0,1);
      check("lit_sound_state", int'(st), 2);
      check("lit_sound_siren", int'(siren), 1);

      // hold, reopen, hold again, expire
      step(0,0,0,0,0,0);
      check("lit_hold_state", int'(st), 3);
      check("lit_hold_interval", int'(intv), 3);
      check("lit_hold_start", int'(start), 1);
      step(0,1,0,0,0,0);
      check("lit_reopen_state", int'(st), 2);
      check("lit_reopen_start", int'(start), 0);
      step(0,0,0,0,0,0);
      check("lit_rehold_start", int'(start), 1);
      repeat (4) step(0,0,0,0,0,0);
      check("lit_hold_wait_state", int'(st), 3);
      step(0,0,0,0,0,1);
      check("lit_rearm_state", int'(st), 0);
      check("lit_rearm_siren", int'(siren), 0);

      // disarm path
      step(0,1,0,0,0,0);
      check("lit_drv_interval", int'(intv), 1);
      step(1,0,0,0,0,0);
      check("lit_disarm_state", int'(st), 4);
      check("lit_disarm_siren", int'(siren), 0);
      step(0,0,0,0,0,0);
      check("lit_wopen_state", int'(st), 5);
      step(0,0,1,0,0,0);
      step(0,0,0,0,0,0);
      check("lit_pass_noadv", int'(st), 5);
      step(0,1,0,0,0,0);
      check("lit_wclose_state", int'(st), 6);
      step(0,0,0,0,0,0);
      check("lit_armdly_state", int'(st), 7);
      check("lit_armdly_interval", int'(intv), 0);
      check("lit_armdly_start", int'(start), 1);

      // reopen during arm delay, then expire 4 cycles after fresh pulse
      step(0,0,1,0,0,1);
      check("lit_armdly_reopen", int'(st), 6);
      check("lit_armdly_reopen_start", int'(start), 0);
      step(0,0,0,0,0,0);
      check("lit_armdly_restart", int'(start), 1);
      repeat (3) step(0,0,0,0,0,0);
      step(0,0,0,0,0,1);
      check("lit_armed_again", int'(st), 0);
      check("lit_armed_led", int'(led), 0);

      // ten 1 Hz ticks toggle the LED ten times
      toggles = 0;
      prev = led;
      for (int k = 1; k <= 10; k++) begin
         step(0,0,0,0,1,0);
         if (led != prev) toggles++;
         prev = led;
         step(0,0,0,0,0,0);
         if (led != prev) toggles++;
         prev = led;
      end
      check("lit_blink_toggles", toggles, 10);

      // both doors at once: driver wins
      step(0,1,1,0,0,0);
      check("lit_both_interval", int'(intv), 1);

      // reprogram out of SOUND_ALARM
      repeat (3) step(0,1,0,0,0,1);
      check("lit_sound2_state", int'(st), 2);
      step(0,1,0,1,0,0);
      check("lit_reprog_state", int'(st), 0);
      check("lit_reprog_siren", int'(siren), 0);
      check("lit_reprog_start", int'(start), 0);
      step(0,0,0,0,0,0);

      // asynchronous reset mid-cycle
      step(0,1,0,0,0,0);
      check("lit_pre_rst_start", int'(start), 1);
      #3 rst = 1'b1;
      #2;
      check("lit_async_state", int'(st), 0);
      check("lit_async_start", int'(start), 0);
      check("lit_async_interval", int'(intv), 0);
      check("lit_async_status", int'(led), 0);
      @(negedge clk);
      rst = 1'b0; dd = 1'b0;

      // randomized stimulus
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         if (rst)                              rst = 1'b0;
         else if ($urandom_range(0, 399) == 0) rst = 1'b1;
         if ($urandom_range(0, 14) == 0) ig = ~ig;
         if ($urandom_range(0, 5) == 0)  dd = ~dd;
         if ($urandom_range(0, 5) == 0)  pd = ~pd;
         if ($urandom_range(0, 3) == 0)  ex = ~ex;
         rp = ($urandom_range(0, 59) == 0);
         hz = ($urandom_range(0, 7) == 0);
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
